matrix_stream_reader: RTL and testbench
=======================================

Name: matrix_stream_reader

Overview:
- Consumer-side reader for packed matrix results, such as the transpose unit's matrixAT with m_out and n_out.
- On start, captures a packed matrix and its dimensions, then emits the elements one at a time in row-major order over a valid/ready stream.
- Feeds the display/UART path, which cannot take a 200-bit word in one go.

Parameters:
- MAX_DIM, 5: maximum rows/cols; matrix packed as MAX_DIM x MAX_DIM slots.
- ELEM_W, 8: bits per element; element (r,c) sits at bit offset (r*MAX_DIM+c)*ELEM_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin reading; sampled only in IDLE.
- m_in  input  3  row count of the packed matrix.
- n_in  input  3  column count of the packed matrix.
- matrix_in  input  MAX_DIM*MAX_DIM*ELEM_W  packed matrix, 200 bits at defaults.
- elem_out  output  ELEM_W  current element value.
- elem_row  output  3  row index of elem_out.
- elem_col  output  3  column index of elem_out.
- elem_valid  output  1  elem_out/elem_row/elem_col/row_last/mat_last are valid.
- elem_ready  input  1  downstream accepts the element; a transfer occurs when elem_valid && elem_ready.
- row_last  output  1  elem_col == n-1 while elem_valid.
- mat_last  output  1  last element of the matrix while elem_valid.
- busy  output  1  high while in SEND.
- done  output  1  one-cycle pulse after the final transfer.
- error  output  1  one-cycle pulse when start arrives with invalid dimensions.

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - state=IDLE.
  - All outputs 0; internal row/col counters, captured dims and captured matrix cleared.
- FSM has two states, IDLE and SEND.
- IDLE, start=1, valid dims (1 <= m_in <= MAX_DIM and 1 <= n_in <= MAX_DIM):
  - Register matrix_in, m_in and n_in; set r=c=0; go to SEND.
  - elem_valid rises on the next cycle, so latency is 1 cycle from start to first valid.
- IDLE, start=1, invalid dims (m_in or n_in equal to 0 or > MAX_DIM):
  - error=1 for exactly one cycle; stay IDLE.
  - No capture; elem_valid stays 0.
- SEND:
  - elem_valid=1 and busy=1.
  - elem_out = captured[(r*MAX_DIM+c)*ELEM_W +: ELEM_W]; elem_row=r, elem_col=c.
  - row_last = (c == n-1); mat_last = (r == m-1 && c == n-1).
- On a transfer in SEND:
  - If c < n-1, then c++.
  - Else c=0 and r++.
  - If mat_last, go to IDLE. elem_valid drops, and done=1 for one cycle in that same next cycle.
- Backpressure: while elem_valid && !elem_ready, every output holds stable and the counters do not advance.
- Throughput: one element per cycle with elem_ready held high. A matrix takes m*n SEND cycles; done is asserted m*n+1 cycles after the start cycle.
- While in SEND:
  - start is ignored.
  - Changes on matrix_in, m_in and n_in have no effect, because the data comes from the captured copy.
- start in the same cycle done is high: accepted, since the state is IDLE. The next matrix begins with no gap beyond the 1-cycle latency.
- Unused slots (c >= n or r >= m) are never emitted.
- Index arithmetic: r*MAX_DIM+c is computed in a width of at least 5 bits to avoid truncation at 24.

Test Plan:
- 1x3 matrix [1,2,3], elem_ready=1, start at cycle 0:
  - elem_out=1,2,3 on cycles 1,2,3 with (row,col)=(0,0),(0,1),(0,2).
  - row_last=1 only on cycle 3; mat_last=1 only on cycle 3.
  - done=1 on cycle 4; busy=0 from cycle 4.
- 3x1 matrix [1;2;3]:
  - Outputs 1,2,3 at rows 0,1,2, col 0.
  - row_last=1 on all three; mat_last only on the third.
- 5x5 matrix with element(r,c)=r*5+c+1, elem_ready=1:
  - 25 transfers with values 1..25 in order.
  - row_last on values 5,10,15,20,25; mat_last on 25; done 26 cycles after start.
- 2x2 [10,20;30,40], elem_ready toggled 1,0,0,1,0,1,1:
  - elem_out holds its value during each low-ready cycle.
  - Exactly 4 transfers, in order 10,20,30,40; done follows the 4th transfer.
- Invalid dims (start with m_in=0 n_in=3, then m_in=2 n_in=6):
  - error pulses one cycle each time; elem_valid and busy stay 0; no done.
- Robustness, part 1: 3x3 stream, with reset asserted asynchronously after the 4th transfer.
  - All outputs drop to 0 immediately.
  - After release, a new 1x1 start emits only the new value.
- Robustness, part 2: a second start and a change of matrix_in mid-stream.
  - Both are ignored; the original values are emitted.

Source files
------------

// File: rtl/matrix_stream_reader_if.sv
// Element stream from the matrix reader to the display/UART path.
interface matrix_stream_reader_if #(
  parameter int unsigned ELEM_W = 8
);
  logic [ELEM_W-1:0] elem_out;
  logic [2:0]        elem_row;
  logic [2:0]        elem_col;
  logic              elem_valid;
  logic              elem_ready;
  logic              row_last;
  logic              mat_last;

  modport master (
    output elem_out, elem_row, elem_col, elem_valid, row_last, mat_last,
    input  elem_ready
  );

  modport slave (
    input  elem_out, elem_row, elem_col, elem_valid, row_last, mat_last,
    output elem_ready
  );
endinterface

// File: rtl/matrix_stream_reader.sv
// Captures a packed MAX_DIM x MAX_DIM matrix plus its dimensions on start and
// streams the used elements out one per transfer in row-major order.
module matrix_stream_reader #(
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned ELEM_W  = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [2:0]                          m_in,
  input  logic [2:0]                          n_in,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_in,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  matrix_stream_reader_if.master              stream
);

  localparam int unsigned MAT_W = MAX_DIM * MAX_DIM * ELEM_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state;
  logic [2:0]       r;
  logic [2:0]       c;
  logic [2:0]       m_q;
  logic [2:0]       n_q;
  logic [MAT_W-1:0] mat_q;

  logic             dims_ok;
  logic             sending;
  logic             last_col;
  logic             last_row;
  logic [31:0]      offset;

  // Dimension check, end-of-row/matrix flags and the slot bit offset (32-bit to avoid truncation)
  always_comb begin
    dims_ok  = (m_in != '0) && (n_in != '0) &&
               (32'(m_in) <= MAX_DIM) && (32'(n_in) <= MAX_DIM);
    sending  = (state == SEND);
    last_col = (c == n_q - 3'd1);
    last_row = (r == m_q - 3'd1);
    offset   = (32'(r) * MAX_DIM + 32'(c)) * ELEM_W;
  end

  // Stream outputs are driven from the captured copy and forced to zero outside SEND
  always_comb begin
    stream.elem_valid = sending;
    stream.elem_out   = sending ? mat_q[offset +: ELEM_W] : '0;
    stream.elem_row   = sending ? r : '0;
    stream.elem_col   = sending ? c : '0;
    stream.row_last   = sending && last_col;
    stream.mat_last   = sending && last_col && last_row;
    busy              = sending;
  end

  // Capture on start, advance row-major on each transfer, pulse done/error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      m_q   <= '0;
      n_q   <= '0;
      mat_q <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (dims_ok) begin
            mat_q <= matrix_in;
            m_q   <= m_in;
            n_q   <= n_in;
            r     <= '0;
            c     <= '0;
            state <= SEND;
          end else begin
            error <= 1'b1;
          end
        end
      end else if (stream.elem_ready) begin
        if (last_col) begin
          c <= '0;
          // Counters return to 0 after the final element so the slot select stays in range
          if (last_row) begin
            r     <= '0;
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            r <= r + 3'd1;
          end
        end else begin
          c <= c + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Directed bench for matrix_stream_reader with hand-computed element sequences.
module tb_matrix_stream_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   m_in;
  logic [2:0]   n_in;
  logic [199:0] matrix_in;
  logic         busy;
  logic         done;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ev [25];
  bit         rdy_q [$];

  matrix_stream_reader_if #(.ELEM_W(8)) stream ();

  matrix_stream_reader #(.MAX_DIM(5), .ELEM_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .m_in      (m_in),
    .n_in      (n_in),
    .matrix_in (matrix_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .stream    (stream)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int r, input int c, input logic [7:0] v);
    matrix_in[(r*5+c)*8 +: 8] = v;
  endtask

  task automatic begin_start(input int m, input int n);
    m_in  = 3'(m);
    n_in  = 3'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Follows an m x n stream already started; expects ev[k] in order, with
  // elem_ready taken from rdy_q (1 once empty). Ends in the done cycle.
  task automatic expect_stream(input string tag, input int m, input int n, input int exp_cycles);
    int k   = 0;
    int cyc = 0;
    while (k < m*n && cyc < exp_cycles + 20) begin
      stream.elem_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      check({tag, "_valid"}, 32'(stream.elem_valid), 1);
      check({tag, "_busy"},  32'(busy), 1);
      check({tag, "_done"},  32'(done), 0);
      check({tag, "_val"},   32'(stream.elem_out), 32'(ev[k]));
      check({tag, "_row"},   32'(stream.elem_row), k / n);
      check({tag, "_col"},   32'(stream.elem_col), k % n);
      check({tag, "_rlast"}, 32'(stream.row_last), 32'((k % n) == n - 1));
      check({tag, "_mlast"}, 32'(stream.mat_last), 32'(k == m*n - 1));
      if (stream.elem_ready) k++;
      tick();
      cyc++;
    end
    check({tag, "_count"},   k, m*n);
    check({tag, "_cycles"},  cyc, exp_cycles);
    check({tag, "_done_p"},  32'(done), 1);
    check({tag, "_end_vld"}, 32'(stream.elem_valid), 0);
    check({tag, "_end_bsy"}, 32'(busy), 0);
    stream.elem_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m_in = '0;
    n_in = '0;
    matrix_in = '0;
    stream.elem_ready = 1'b1;
    #1;
    check("rst_valid", 32'(stream.elem_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_elem",  32'(stream.elem_out), 0);
    #22;
    reset = 1'b0;
    tick();

    // 1x3 [1,2,3]: values on cycles 1..3, done on cycle 4
    matrix_in = '0;
    put(0, 0, 8'd1); put(0, 1, 8'd2); put(0, 2, 8'd3);
    ev[0] = 8'd1; ev[1] = 8'd2; ev[2] = 8'd3;
    begin_start(1, 3);
    expect_stream("m1x3", 1, 3, 3);

    // 3x1 [1;2;3] started in the done cycle of the previous matrix
    matrix_in = '0;
    put(0, 0, 8'd1); put(1, 0, 8'd2); put(2, 0, 8'd3);
    begin_start(3, 1);
    expect_stream("m3x1", 3, 1, 3);
    tick();

    // 5x5 with element(r,c) = r*5+c+1, done 26 cycles after start
    matrix_in = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        put(r, c, 8'(r*5 + c + 1));
        ev[r*5 + c] = 8'(r*5 + c + 1);
      end
    begin_start(5, 5);
    expect_stream("m5x5", 5, 5, 25);
    tick();

    // 2x2 [10,20;30,40] with ready pattern 1,0,0,1,0,1,1
    matrix_in = '0;
    put(0, 0, 8'd10); put(0, 1, 8'd20); put(1, 0, 8'd30); put(1, 1, 8'd40);
    ev[0] = 8'd10; ev[1] = 8'd20; ev[2] = 8'd30; ev[3] = 8'd40;
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    begin_start(2, 2);
    expect_stream("m2x2bp", 2, 2, 7);
    tick();

    // Invalid dimensions: one-cycle error, nothing else moves
    begin_start(0, 3);
    check("inv0_error", 32'(error), 1);
    check("inv0_valid", 32'(stream.elem_valid), 0);
    check("inv0_busy",  32'(busy), 0);
    tick();
    check("inv0_error_off", 32'(error), 0);
    check("inv0_done",      32'(done), 0);
    check("inv0_valid2",    32'(stream.elem_valid), 0);
    begin_start(2, 6);
    check("inv6_error", 32'(error), 1);
    check("inv6_valid", 32'(stream.elem_valid), 0);
    check("inv6_busy",  32'(busy), 0);
    tick();
    check("inv6_error_off", 32'(error), 0);
    check("inv6_done",      32'(done), 0);

    // 3x3 stream (values 11..19), async reset after the 4th transfer
    matrix_in = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        put(r, c, 8'(r*3 + c + 11));
    begin_start(3, 3);
    for (int k = 0; k < 4; k++) begin
      check("rob_val", 32'(stream.elem_out), 32'(k + 11));
      tick();
    end
    check("rob_pre_val", 32'(stream.elem_out), 15);
    check("rob_pre_row", 32'(stream.elem_row), 1);
    reset = 1'b1;
    #1;
    check("rob_rst_valid", 32'(stream.elem_valid), 0);
    check("rob_rst_busy",  32'(busy), 0);
    check("rob_rst_elem",  32'(stream.elem_out), 0);
    check("rob_rst_row",   32'(stream.elem_row), 0);
    check("rob_rst_col",   32'(stream.elem_col), 0);
    check("rob_rst_rlast", 32'(stream.row_last), 0);
    check("rob_rst_done",  32'(done), 0);
    #2;
    reset = 1'b0;
    tick();
    matrix_in = '0;
    put(0, 0, 8'd99);
    ev[0] = 8'd99;
    begin_start(1, 1);
    expect_stream("rob_1x1", 1, 1, 1);
    tick();

    // 2x2 [5,6;7,8]; a second start and new inputs mid-stream are ignored
    matrix_in = '0;
    put(0, 0, 8'd5); put(0, 1, 8'd6); put(1, 0, 8'd7); put(1, 1, 8'd8);
    ev[0] = 8'd5; ev[1] = 8'd6; ev[2] = 8'd7; ev[3] = 8'd8;
    begin_start(2, 2);
    start = 1'b1;
    matrix_in = '1;
    m_in = 3'd5;
    n_in = 3'd5;
    expect_stream("ign", 2, 2, 4);
    start = 1'b0;
    tick();
    check("ign_idle_valid", 32'(stream.elem_valid), 0);
    check("ign_idle_error", 32'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
